neuron_mac: RTL and testbench

//  Producer side of the 2*dataWidth activation bus. Streams numWeight signed fixed-point

---
 rtl/neuron_mac.sv | 103 ++++++++++
 tb/tb_neuron_mac.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Weight-stationary MAC neuron: streams numWeight signed fixed-point inputs against a local
// weight memory, accumulates with saturation, adds an aligned bias and pulses one 2*dataWidth sum.
module neuron_mac #(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int numWeight      = 784,
  parameter int addressWidth   = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      weightWen,
  input  logic [addressWidth-1:0]   weightAddr,
  input  logic [dataWidth-1:0]      weightIn,
  input  logic [dataWidth-1:0]      bias,
  input  logic [dataWidth-1:0]      myinput,
  input  logic                      myinputValid,
  output logic [2*dataWidth-1:0]    out,
  output logic                      outValid
);

  localparam int AccW  = 2 * dataWidth;
  localparam int FracW = dataWidth - weightIntWidth;
  localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);
  localparam logic signed [AccW-1:0] SatMax = {1'b0, {(AccW-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {1'b1, {(AccW-1){1'b0}}};

  // One extra guard bit exposes signed overflow as a mismatch of the top two bits.
  function automatic logic signed [AccW-1:0] sat_add(input logic signed [AccW-1:0] a,
                                                     input logic signed [AccW-1:0] b);
    logic signed [AccW:0] s;
    s = {a[AccW-1], a} + {b[AccW-1], b};
    if (s[AccW] != s[AccW-1]) return s[AccW] ? SatMin : SatMax;
    return s[AccW-1:0];
  endfunction

  logic [dataWidth-1:0] weight_mem [numWeight];

  logic [addressWidth-1:0] count_q, count_d;
  logic                    v1_q, first1_q, last1_q;
  logic [dataWidth-1:0]    in1_q, w1_q;
  logic                    v2_q, first2_q, last2_q;
  logic signed [AccW-1:0]  prod2_q, prod_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic                    last3_q;
  logic [dataWidth-1:0]    bias_q;
  logic signed [AccW-1:0]  bias_ext;
  logic [AccW-1:0]         out_q;
  logic                    outValid_q;

  // Weight array kept free of reset so it can map onto block RAM; read-before-write on collision.
  always_ff @(posedge clk) begin
    if (weightWen && (weightAddr <= LastAddr)) weight_mem[weightAddr] <= weightIn;
    if (myinputValid) w1_q <= weight_mem[count_q];
  end

  always_comb begin
    count_d  = count_q;
    if (myinputValid) count_d = (count_q == LastAddr) ? '0 : count_q + 1'b1;
    prod_d   = AccW'($signed(in1_q)) * AccW'($signed(w1_q));
    acc_d    = acc_q;
    if (v2_q) acc_d = first2_q ? prod2_q : sat_add(acc_q, prod2_q);
    bias_ext = AccW'($signed(bias_q)) <<< FracW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      v1_q       <= 1'b0;
      first1_q   <= 1'b0;
      last1_q    <= 1'b0;
      in1_q      <= '0;
      v2_q       <= 1'b0;
      first2_q   <= 1'b0;
      last2_q    <= 1'b0;
      prod2_q    <= '0;
      acc_q      <= '0;
      last3_q    <= 1'b0;
      bias_q     <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      v1_q       <= myinputValid;
      first1_q   <= myinputValid && (count_q == '0);
      last1_q    <= myinputValid && (count_q == LastAddr);
      if (myinputValid) in1_q <= myinput;
      v2_q       <= v1_q;
      first2_q   <= first1_q;
      last2_q    <= last1_q;
      if (v1_q) prod2_q <= prod_d;
      acc_q      <= acc_d;
      last3_q    <= v2_q && last2_q;
      if (v2_q && last2_q) bias_q <= bias;
      // Bias stage reads acc_q before a back-to-back first-tag load overwrites it.
      if (last3_q) out_q <= sat_add(acc_q, bias_ext);
      outValid_q <= last3_q;
    end
  end

  assign out      = out_q;
  assign outValid = outValid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: a saturating fixed-point sum model predicts each output
// value and its arrival cycle; a monitor checks every pulse and that out holds in between.
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          weightWen = 1'b0;
  logic [AW-1:0] weightAddr = '0;
  logic [DW-1:0] weightIn = '0;
  logic [DW-1:0] bias = '0;
  logic [DW-1:0] myinput = '0;
  logic          myinputValid = 1'b0;
  logic [2*DW-1:0] out;
  logic          outValid;

  neuron_mac #(.dataWidth(DW), .weightIntWidth(4), .numWeight(NW), .addressWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n), .weightWen(weightWen), .weightAddr(weightAddr),
    .weightIn(weightIn), .bias(bias), .myinput(myinput), .myinputValid(myinputValid),
    .out(out), .outValid(outValid)
  );

  always #5 clk = ~clk;

  typedef struct { longint acc; int at; } pend_t;
  typedef struct { logic [31:0] val; int at; } exp_t;

  int       cyc = 0;
  int       tests = 0;
  int       fails = 0;
  pend_t    pend[$];
  exp_t     sb[$];
  longint   wmem[NW];
  longint   m_acc = 0;
  int       pos = 0;
  logic [31:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Bias is taken at the edge that accumulates the last product.
  always @(posedge clk) begin
    if (rst_n && pend.size() > 0 && pend[0].at == cyc + 1) begin
      pend_t p;
      exp_t  e;
      longint v;
      p = pend.pop_front();
      v = clamp(p.acc + longint'($signed(bias)) * 4096);
      e.val = v[31:0];
      e.at  = p.at + 1;
      sb.push_back(e);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      last_out = '0;
    end else if (outValid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pulse: unexpected outValid with out=0x%08h at cycle %0d, want no pulse", out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out !== e.val || cyc != e.at) begin
          fails++;
          $display("FAIL sum: got 0x%08h at cycle %0d, want 0x%08h at cycle %0d", out, cyc, e.val, e.at);
        end
        last_out = e.val;
      end
    end else begin
      tests++;
      if (out !== last_out) begin
        fails++;
        $display("FAIL hold: got out=0x%08h at cycle %0d, want 0x%08h", out, cyc, last_out);
      end
    end
  end

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    myinputValid = 1'b0;
    weightWen = 1'b1;
    weightAddr = AW'(a);
    weightIn = d;
    wmem[a] = longint'($signed(d));
    @(negedge clk);
    weightWen = 1'b0;
  endtask

  task automatic wr_all(input logic [DW-1:0] w0, w1, w2, w3);
    wr(0, w0); wr(1, w1); wr(2, w2); wr(3, w3);
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] b);
    longint prod;
    pend_t  p;
    @(negedge clk);
    myinputValid = 1'b1;
    myinput = x;
    bias = b;
    prod = longint'($signed(x)) * wmem[pos];
    m_acc = (pos == 0) ? prod : clamp(m_acc + prod);
    if (pos == NW - 1) begin
      p.acc = m_acc;
      p.at  = cyc + 3;
      pend.push_back(p);
    end
    pos = (pos + 1) % NW;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) myinputValid = 1'b0;
  endtask

  task automatic vec(input logic [DW-1:0] x0, x1, x2, x3, input logic [DW-1:0] b, input int maxgap);
    send(x0, b); idle($urandom_range(0, maxgap));
    send(x1, b); idle($urandom_range(0, maxgap));
    send(x2, b); idle($urandom_range(0, maxgap));
    send(x3, b);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || pend.size() > 0) && n < 50) begin
      idle(1);
      n++;
    end
    idle(2);
    tests++;
    if (sb.size() > 0 || pend.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d results still outstanding, want 0", sb.size() + pend.size());
      sb.delete();
      pend.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    myinputValid = 1'b0;
    pend.delete();
    sb.delete();
    pos = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (out !== '0 || outValid !== 1'b0) begin
      fails++;
      $display("FAIL reset: got out=0x%08h valid=%0b, want 0x00000000 valid=0", out, outValid);
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) wmem[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_reset();

    wr_all(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 0);
    drain();

    wr_all(16'h1000, 16'h2000, 16'hF000, 16'h0800);
    vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000, 0);
    drain();

    wr_all(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
    drain();
    wr_all(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 0);
    drain();

    // Back-to-back; second vector's bias changes only after the first one sampled it.
    wr_all(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 0);
    send(16'h1000, 16'h1000); send(16'h2000, 16'h1000); send(16'hF000, 16'h1000);
    send(16'h0800, 16'h0000);
    drain();

    vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 5);
    idle($urandom_range(0, 5));
    wr(0, 16'h2000);
    vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 5);
    drain();

    wr(0, 16'h1000);
    send(16'h1000, 16'h1000); send(16'h1000, 16'h1000);
    do_reset();
    vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 0);
    drain();

    for (int v = 0; v < 30; v++) begin
      if (v % 5 == 0)
        wr_all(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      else if (v % 3 == 0)
        wr(int'($urandom_range(0, NW - 1)), DW'($urandom));
      vec(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 2);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
